elevator_control: RTL and testbench
===================================

Name: elevator_control

Overview:
- Car-motion controller at the consumer end of the elevator request path.
- Reads the three request queues (queueUp, queueDown, queueinside) produced by the request-input block and runs a collective/SCAN service policy: keep moving in the current direction while requests lie ahead, reverse only when none remain.
- Drives the car floor, direction and door outputs.
- Returns per-floor clear masks so the input block drops served requests.

Parameters:
- FLOORS, 4, number of floors; all floor buses are FLOORS bits, one bit per floor, bit 0 = ground.
- MOVE_CYCLES, 4, clock cycles to travel one floor (≥2).
- DOOR_CYCLES, 3, cycles the door stays open per stop (≥1).

Ports:
- clk  input  1  controller clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- queueUp  input  FLOORS  pending hall-up requests, level, held until cleared.
- queueDown  input  FLOORS  pending hall-down requests, level.
- queueinside  input  FLOORS  pending in-car requests, level.
- curFloor  output  FLOORS  one-hot current floor.
- dirUp  output  1  car moving/committed upward.
- dirDown  output  1  car moving/committed downward; dirUp and dirDown never both 1.
- doorOpen  output  1  door open.
- clearUp  output  FLOORS  clear mask for queueUp (level).
- clearDown  output  FLOORS  clear mask for queueDown (level).
- clearInside  output  FLOORS  clear mask for queueinside (level).

Behaviour:
- Interface: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state=IDLE, curFloor=0…01, dirUp=dirDown=0, doorOpen=0, all clear masks 0, counters 0.
  - Reset mid-move or with the door open aborts immediately; no completion of the move or door cycle.
- Helpers, combinational on the current floor index f:
  - req = queueUp|queueDown|queueinside.
  - above = |req[FLOORS-1:f+1].
  - below = |req[f-1:0].
  - here = req[f].
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. All outputs are registered.
- IDLE:
  - here → DOOR_OPEN next edge; serve all three bits at f.
  - else above → MOVE_UP, dirUp=1.
  - else below → MOVE_DOWN, dirDown=1.
  - else stay. Priority is here > above > below.
- MOVE_UP / MOVE_DOWN:
  - moveCnt clears on entry and increments each cycle.
  - At the edge where moveCnt==MOVE_CYCLES-1, curFloor shifts one position (up or down) and the stop test is evaluated on the new floor n.
  - Stop going up when: queueinside[n] | queueUp[n] | (queueDown[n] & no request above n) | n==FLOORS-1.
  - Going down is symmetric, with queueUp served only when nothing is below n, or n==0.
  - On stop → DOOR_OPEN. Otherwise moveCnt restarts at 0.
- DOOR_OPEN:
  - doorOpen=1 for exactly DOOR_CYCLES cycles.
  - Clear masks are held on bit f for the whole interval:
    - clearInside[f]=1.
    - clearUp[f]=1 if going up, or if idle/reversing with nothing above.
    - clearDown[f]=1 if going down, or if nothing below.
  - This absorbs the input block's clear latency and any same-floor re-press without reopening the door.
  - At the closing edge, masks go to 0 and doorOpen goes to 0.
  - Next state, from the queues at that edge with the current floor excluded:
    - Current direction with requests ahead → keep it.
    - Else requests behind → reverse.
    - Else IDLE, dir bits 0.
- Boundaries:
  - Never move past floor 0 or FLOORS-1.
  - A request for a floor already passed is served on the return sweep.
  - Simultaneous requests at several floors are served in sweep order.
  - Queue bits that change mid-move are sampled only at the arrival edge.

Decomposition:
- Shared package elevator_pkg holds:
  - FLOORS default.
  - state encoding (IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=3).
  - direction constants.
  - the one-hot ↔ index conversion function.
- One combinational sub-module, request_scan: inputs are the three queues and the floor index; outputs are above, below, here, plus the up and down stop flags for a given floor. It is instantiated once for the current floor and once for the next floor.

Test Plan (MOVE_CYCLES=4, DOOR_CYCLES=3):
1. Hold rst=1 for 2 cycles, queues 0 → curFloor=0001, doorOpen=0, dirUp=dirDown=0, all clears 0000.
2. At floor 0, pulse-then-hold queueUp=0010 until clearUp[1]:
   - dirUp=1 one edge later.
   - curFloor=0010 four edges after that, with doorOpen=1 and clearUp=0010 on the same edge.
   - Door closes after 3 cycles → IDLE.
3. At floor 0, queueinside=0100 and queueDown=0010 together:
   - Car passes floor 1 without stopping and stops at 2 with clearInside=0100.
   - Then reverses and stops at 1 with clearDown=0010.
4. IDLE at floor 2, queueinside=0100:
   - doorOpen=1 next edge, no motion.
   - Re-press during the door interval does not extend the door beyond 3 cycles.
5. queueUp=1000 plus queueinside=0001 while at floor 1 going up:
   - Continues to floor 3 first.
   - Then returns down to floor 0.
6. Assert rst for 1 cycle during MOVE_UP halfway between floors 1 and 2 → next edge curFloor=0001, IDLE, all outputs at reset values.

Source files
------------

// File: rtl/elevator_pkg.sv
// ============================================================================
// Module : elevator_pkg
// Brief  : Shared encodings and helpers for the elevator car controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

    localparam int c_FLOORS_DEFAULT = 4;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_MOVE_UP   = 2'd1;
    localparam logic [1:0] c_ST_MOVE_DOWN = 2'd2;
    localparam logic [1:0] c_ST_DOOR_OPEN = 2'd3;

    localparam logic [1:0] c_DIR_NONE = 2'b00;
    localparam logic [1:0] c_DIR_UP   = 2'b01;
    localparam logic [1:0] c_DIR_DOWN = 2'b10;

    // Highest set bit wins, so a malformed vector still yields a legal floor.
    function automatic int oneHotToIndex(input logic [31:0] oneHot);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oneHot[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_control_request_scan.sv
// ============================================================================
// Module : request_scan
// Brief  : Combinational view of pending requests relative to one floor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module request_scan
    import elevator_pkg::*;
#(
    parameter int FLOORS = c_FLOORS_DEFAULT,
    parameter int IDX_W  = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
    input  logic [FLOORS-1:0] queueUp,
    input  logic [FLOORS-1:0] queueDown,
    input  logic [FLOORS-1:0] queueInside,
    input  logic [IDX_W-1:0]  floorIdx,
    output logic              above,
    output logic              below,
    output logic              here,
    output logic              stopUp,
    output logic              stopDown
);

    logic [FLOORS-1:0] w_req;
    logic              w_upHere;
    logic              w_downHere;
    logic              w_insideHere;

    always_comb begin
        w_req        = queueUp | queueDown | queueInside;
        above        = 1'b0;
        below        = 1'b0;
        here         = 1'b0;
        w_upHere     = 1'b0;
        w_downHere   = 1'b0;
        w_insideHere = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(floorIdx)) above = above | w_req[i];
            if (i < int'(floorIdx)) below = below | w_req[i];
            if (i == int'(floorIdx)) begin
                here         = w_req[i];
                w_upHere     = queueUp[i];
                w_downHere   = queueDown[i];
                w_insideHere = queueInside[i];
            end
        end
        // Opposite-direction hall calls are only worth a stop at the sweep's end.
        stopUp   = w_insideHere | w_upHere | (w_downHere & ~above)
                 | (int'(floorIdx) == FLOORS - 1);
        stopDown = w_insideHere | w_downHere | (w_upHere & ~below)
                 | (int'(floorIdx) == 0);
    end

endmodule

`default_nettype wire

// File: rtl/elevator_control.sv
// ============================================================================
// Module : elevator_control
// Brief  : SCAN-policy car controller driving floor, direction and door.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module elevator_control
    import elevator_pkg::*;
#(
    parameter int FLOORS      = c_FLOORS_DEFAULT,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] queueUp,
    input  logic [FLOORS-1:0] queueDown,
    input  logic [FLOORS-1:0] queueinside,
    output logic [FLOORS-1:0] curFloor,
    output logic              dirUp,
    output logic              dirDown,
    output logic              doorOpen,
    output logic [FLOORS-1:0] clearUp,
    output logic [FLOORS-1:0] clearDown,
    output logic [FLOORS-1:0] clearInside
);

    localparam int c_IDX_W  = (FLOORS > 1) ? $clog2(FLOORS) : 1;
    localparam int c_MOVE_W = $clog2(MOVE_CYCLES);
    localparam int c_DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [c_MOVE_W-1:0] c_MOVE_LAST = c_MOVE_W'(MOVE_CYCLES - 1);
    localparam logic [c_DOOR_W-1:0] c_DOOR_LAST = c_DOOR_W'(DOOR_CYCLES - 1);

    logic [1:0]          r_state;
    logic [1:0]          r_dir;
    logic [FLOORS-1:0]   r_curFloor;
    logic                r_doorOpen;
    logic [FLOORS-1:0]   r_clearUp;
    logic [FLOORS-1:0]   r_clearDown;
    logic [FLOORS-1:0]   r_clearInside;
    logic [c_MOVE_W-1:0] r_moveCnt;
    logic [c_DOOR_W-1:0] r_doorCnt;

    logic [c_IDX_W-1:0]  w_curIdx;
    logic [c_IDX_W-1:0]  w_nextIdx;
    logic [FLOORS-1:0]   w_nextFloor;
    logic                w_goingUp;
    logic                w_curAbove, w_curBelow, w_curHere, w_curStopUp, w_curStopDown;
    logic                w_nextAbove, w_nextBelow, w_nextHere, w_nextStopUp, w_nextStopDown;
    logic                w_stopNext;
    logic                w_unusedScan;

    assign w_curIdx    = c_IDX_W'(oneHotToIndex(32'(r_curFloor)));
    assign w_goingUp   = (r_state == c_ST_MOVE_UP);
    // Only meaningful while moving; the wrap at the shaft ends is never consumed.
    assign w_nextIdx   = w_goingUp ? w_curIdx + c_IDX_W'(1) : w_curIdx - c_IDX_W'(1);
    assign w_nextFloor = w_goingUp ? (r_curFloor << 1) : (r_curFloor >> 1);
    assign w_stopNext  = w_goingUp ? w_nextStopUp : w_nextStopDown;
    assign w_unusedScan = ^{w_curStopUp, w_curStopDown, w_nextHere};

    request_scan #(.FLOORS(FLOORS), .IDX_W(c_IDX_W)) u_scanCur (
        .queueUp     (queueUp),
        .queueDown   (queueDown),
        .queueInside (queueinside),
        .floorIdx    (w_curIdx),
        .above       (w_curAbove),
        .below       (w_curBelow),
        .here        (w_curHere),
        .stopUp      (w_curStopUp),
        .stopDown    (w_curStopDown)
    );

    request_scan #(.FLOORS(FLOORS), .IDX_W(c_IDX_W)) u_scanNext (
        .queueUp     (queueUp),
        .queueDown   (queueDown),
        .queueInside (queueinside),
        .floorIdx    (w_nextIdx),
        .above       (w_nextAbove),
        .below       (w_nextBelow),
        .here        (w_nextHere),
        .stopUp      (w_nextStopUp),
        .stopDown    (w_nextStopDown)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_dir         <= c_DIR_NONE;
            r_curFloor    <= FLOORS'(1);
            r_doorOpen    <= 1'b0;
            r_clearUp     <= '0;
            r_clearDown   <= '0;
            r_clearInside <= '0;
            r_moveCnt     <= '0;
            r_doorCnt     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_curHere) begin
                        r_state       <= c_ST_DOOR_OPEN;
                        r_doorOpen    <= 1'b1;
                        r_doorCnt     <= '0;
                        r_clearInside <= r_curFloor;
                        r_clearUp     <= w_curAbove ? '0 : r_curFloor;
                        r_clearDown   <= w_curBelow ? '0 : r_curFloor;
                    end else if (w_curAbove) begin
                        r_state   <= c_ST_MOVE_UP;
                        r_dir     <= c_DIR_UP;
                        r_moveCnt <= '0;
                    end else if (w_curBelow) begin
                        r_state   <= c_ST_MOVE_DOWN;
                        r_dir     <= c_DIR_DOWN;
                        r_moveCnt <= '0;
                    end
                end
                c_ST_MOVE_UP, c_ST_MOVE_DOWN: begin
                    if (r_moveCnt == c_MOVE_LAST) begin
                        r_curFloor <= w_nextFloor;
                        r_moveCnt  <= '0;
                        if (w_stopNext) begin
                            r_state       <= c_ST_DOOR_OPEN;
                            r_doorOpen    <= 1'b1;
                            r_doorCnt     <= '0;
                            r_clearInside <= w_nextFloor;
                            r_clearUp     <= (w_goingUp || !w_nextAbove) ? w_nextFloor : '0;
                            r_clearDown   <= (!w_goingUp || !w_nextBelow) ? w_nextFloor : '0;
                        end
                    end else begin
                        r_moveCnt <= r_moveCnt + c_MOVE_W'(1);
                    end
                end
                c_ST_DOOR_OPEN: begin
                    if (r_doorCnt == c_DOOR_LAST) begin
                        r_doorOpen    <= 1'b0;
                        r_clearUp     <= '0;
                        r_clearDown   <= '0;
                        r_clearInside <= '0;
                        r_moveCnt     <= '0;
                        // Keep sweeping while work lies ahead, otherwise turn around.
                        if (r_dir == c_DIR_UP && w_curAbove) begin
                            r_state <= c_ST_MOVE_UP;
                        end else if (r_dir == c_DIR_DOWN && w_curBelow) begin
                            r_state <= c_ST_MOVE_DOWN;
                        end else if (w_curAbove) begin
                            r_state <= c_ST_MOVE_UP;
                            r_dir   <= c_DIR_UP;
                        end else if (w_curBelow) begin
                            r_state <= c_ST_MOVE_DOWN;
                            r_dir   <= c_DIR_DOWN;
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_dir   <= c_DIR_NONE;
                        end
                    end else begin
                        r_doorCnt <= r_doorCnt + c_DOOR_W'(1);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign curFloor    = r_curFloor;
    assign dirUp       = (r_dir == c_DIR_UP);
    assign dirDown     = (r_dir == c_DIR_DOWN);
    assign doorOpen    = r_doorOpen;
    assign clearUp     = r_clearUp;
    assign clearDown   = r_clearDown;
    assign clearInside = r_clearInside;

endmodule

`default_nettype wire

// File: tb/tb_elevator_control.sv
// ============================================================================
// Module : tb_elevator_control
// Brief  : Directed scoreboard bench for the elevator car controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_elevator_control;

    localparam int c_FLOORS = 4;
    localparam int c_MOVE   = 4;
    localparam int c_DOOR   = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [c_FLOORS-1:0] queueUp, queueDown, queueinside;
    logic [c_FLOORS-1:0] curFloor, clearUp, clearDown, clearInside;
    logic                dirUp, dirDown, doorOpen;

    typedef struct {
        logic [c_FLOORS-1:0] floorOh;
        logic [c_FLOORS-1:0] clrUp;
        logic [c_FLOORS-1:0] clrDown;
        logic [c_FLOORS-1:0] clrIn;
        int                  lat;
    } stop_t;

    stop_t expQ[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    elevator_control #(
        .FLOORS      (c_FLOORS),
        .MOVE_CYCLES (c_MOVE),
        .DOOR_CYCLES (c_DOOR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .queueUp     (queueUp),
        .queueDown   (queueDown),
        .queueinside (queueinside),
        .curFloor    (curFloor),
        .dirUp       (dirUp),
        .dirDown     (dirDown),
        .doorOpen    (doorOpen),
        .clearUp     (clearUp),
        .clearDown   (clearDown),
        .clearInside (clearInside)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock, sampled 1ns after the edge; the request queues drop served bits
    // the way the input block would.
    task automatic tick();
        @(posedge clk);
        #1;
        queueUp     = queueUp & ~clearUp;
        queueDown   = queueDown & ~clearDown;
        queueinside = queueinside & ~clearInside;
    endtask

    task automatic pushStop(input logic [3:0] f, input logic [3:0] cu, input logic [3:0] cd,
                            input logic [3:0] ci, input int lat);
        stop_t e;
        e.floorOh = f;
        e.clrUp   = cu;
        e.clrDown = cd;
        e.clrIn   = ci;
        e.lat     = lat;
        expQ.push_back(e);
    endtask

    task automatic serveNext(input string tag, input int budget, input bit repress);
        int    waited;
        int    openCycles;
        stop_t e;
        waited = 0;
        while (doorOpen !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        check({tag, "_arrive"}, 32'(doorOpen), 32'd1);
        check({tag, "_sbq"}, 32'(expQ.size() > 0), 32'd1);
        if (doorOpen === 1'b1 && expQ.size() > 0) begin
            e = expQ.pop_front();
            if (e.lat > 0) check({tag, "_latency"}, 32'(waited), 32'(e.lat));
            check({tag, "_floor"}, 32'(curFloor), 32'(e.floorOh));
            check({tag, "_clrUp"}, 32'(clearUp), 32'(e.clrUp));
            check({tag, "_clrDown"}, 32'(clearDown), 32'(e.clrDown));
            check({tag, "_clrIn"}, 32'(clearInside), 32'(e.clrIn));
            openCycles = 1;
            if (repress) queueinside = queueinside | curFloor;
            while (doorOpen === 1'b1 && openCycles < 20) begin
                tick();
                if (doorOpen === 1'b1) openCycles++;
            end
            check({tag, "_doorLen"}, 32'(openCycles), 32'(c_DOOR));
        end
    endtask

    task automatic waitFloor(input string tag, input logic [3:0] f, input int budget);
        int w;
        w = 0;
        while (curFloor !== f && w < budget) begin
            tick();
            w++;
        end
        check({tag, "_reach"}, 32'(curFloor), 32'(f));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        queueUp     = '0;
        queueDown   = '0;
        queueinside = '0;
        tick();
        tick();
        check("rst_floor", 32'(curFloor), 32'h1);
        check("rst_door", 32'(doorOpen), 32'h0);
        check("rst_dirUp", 32'(dirUp), 32'h0);
        check("rst_dirDown", 32'(dirDown), 32'h0);
        check("rst_clears", 32'({clearUp, clearDown, clearInside}), 32'h0);

        // Single hall-up call one floor above.
        rst     = 1'b0;
        queueUp = 4'b0010;
        tick();
        check("t2_dirUp", 32'(dirUp), 32'h1);
        check("t2_dirDown", 32'(dirDown), 32'h0);
        pushStop(4'b0010, 4'b0010, 4'b0010, 4'b0010, c_MOVE);
        serveNext("t2", 20, 1'b0);
        check("t2_idleDir", 32'({dirUp, dirDown}), 32'h0);
        tick();
        check("t2_stayFloor", 32'(curFloor), 32'h2);

        queueinside = 4'b0001;
        pushStop(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1 + c_MOVE);
        serveNext("prep0", 40, 1'b0);

        // Down call on floor 1 is skipped on the up sweep, served on the way back.
        queueinside = 4'b0100;
        queueDown   = 4'b0010;
        pushStop(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1 + 2 * c_MOVE);
        pushStop(4'b0010, 4'b0010, 4'b0010, 4'b0010, 0);
        serveNext("t3up", 40, 1'b0);
        check("t3_reverse", 32'({dirUp, dirDown}), 32'h1);
        serveNext("t3down", 40, 1'b0);

        queueinside = 4'b0100;
        pushStop(4'b0100, 4'b0100, 4'b0100, 4'b0100, 1 + c_MOVE);
        serveNext("prep2", 40, 1'b0);

        // Same-floor call from idle, re-pressed while the door is open.
        queueinside = 4'b0100;
        pushStop(4'b0100, 4'b0100, 4'b0100, 4'b0100, 1);
        serveNext("t4", 10, 1'b1);
        tick();
        tick();
        check("t4_noReopen", 32'(doorOpen), 32'h0);
        check("t4_noMotion", 32'({curFloor, dirUp, dirDown}), 32'({4'b0100, 2'b00}));

        queueinside = 4'b0001;
        pushStop(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1 + 2 * c_MOVE);
        serveNext("prep0b", 40, 1'b0);

        // Car call below arrives while sweeping up: top floor first, then back down.
        queueUp = 4'b1000;
        waitFloor("t5", 4'b0010, 20);
        check("t5_goingUp", 32'(dirUp), 32'h1);
        queueinside = 4'b0001;
        pushStop(4'b1000, 4'b1000, 4'b0000, 4'b1000, 2 * c_MOVE);
        pushStop(4'b0001, 4'b0001, 4'b0001, 4'b0001, 3 * c_MOVE);
        serveNext("t5top", 40, 1'b0);
        check("t5_reverse", 32'(dirDown), 32'h1);
        serveNext("t5bottom", 40, 1'b0);

        // Reset halfway between floors 1 and 2.
        queueinside = 4'b0100;
        waitFloor("t6", 4'b0010, 20);
        tick();
        tick();
        check("t6_moving", 32'({doorOpen, dirUp}), 32'h1);
        rst = 1'b1;
        tick();
        check("t6_floor", 32'(curFloor), 32'h1);
        check("t6_dirs", 32'({dirUp, dirDown}), 32'h0);
        check("t6_door", 32'(doorOpen), 32'h0);
        check("t6_clears", 32'({clearUp, clearDown, clearInside}), 32'h0);
        rst         = 1'b0;
        queueinside = '0;
        tick();
        tick();
        check("t6_idle", 32'({curFloor, dirUp, dirDown, doorOpen}), 32'({4'b0001, 3'b000}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
